// File: rtl/cart_backup_ctrl.sv
// -----------------------------------------------------------------------------
// cart_backup_ctrl
//
// Moves battery-backed cartridge RAM to and from the SD save file.
//   load: consecutive 512-byte sectors are read from the save file and
//         written into cart RAM.
//   save: cart RAM is streamed out to the save file, one sector at a time.
// The cartridge RAM size sets the number of sectors. Word addressing inside
// cart RAM is {sector[7:0], word-in-sector[7:0]}.
//
// Ports
//   clk_sys        system clock, everything on the rising edge
//   reset_n        asynchronous active-low reset
//   bk_ena         save file mounted and writable; requests ignored when 0
//   bk_load        load request level; rising edge starts a load
//   bk_save        save request level; rising edge starts a save
//   mbc2           cartridge is MBC2 (512 x 4-bit RAM)
//   cart_ram_size  header RAM-size byte
//   sd_lba         sector number (bits 31:8 always 0)
//   sd_rd / sd_wr  sector read (load) / write (save) request
//   sd_ack         SD host acknowledge, high for one whole sector transfer
//   sd_buff_addr   16-bit word index within the sector
//   sd_buff_wr     sd_buff_dout valid (load direction)
//   sd_buff_dout   word from SD
//   sd_buff_din    word to SD (cart RAM read data, passed straight through)
//   bk_addr        cart-RAM word address
//   bk_wr          cart-RAM word write strobe
//   bk_data        word to cart RAM
//   bk_q           word read from cart RAM (1-cycle read latency)
//   busy           transfer in progress
//   done           one-cycle pulse when a transfer completes
//   dbg_state      current controller state (0 idle, 1 request, 2 transfer)
//
// SD handshake: the controller raises sd_rd or sd_wr and holds it until it
// sees a rising edge of sd_ack; it then drops the request and waits for
// sd_ack to fall, which marks the end of that sector. Words move only while
// sd_ack is high.
// -----------------------------------------------------------------------------
module cart_backup_ctrl (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        bk_ena,
  input  logic        bk_load,
  input  logic        bk_save,
  input  logic        mbc2,
  input  logic [7:0]  cart_ram_size,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic        sd_buff_wr,
  input  logic [15:0] sd_buff_dout,
  output logic [15:0] sd_buff_din,
  output logic [15:0] bk_addr,
  output logic        bk_wr,
  output logic [15:0] bk_data,
  input  logic [15:0] bk_q,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_lba;
  logic        r_dir_load;
  logic        r_rd;
  logic        r_wr;
  logic        r_busy;
  logic        r_done;
  logic        r_old_load;
  logic        r_old_save;
  logic        r_old_ack;

  logic [7:0]  w_last;
  logic        w_supported;
  logic        w_load_edge;
  logic        w_save_edge;
  logic        w_start;
  logic        w_ack_rise;
  logic        w_ack_fall;

  // Index of the final sector for the fitted RAM size.
  always_comb begin
    w_last = 8'hFF;
    if (mbc2) begin
      w_last = 8'h01;
    end else begin
      case (cart_ram_size)
        8'd1:    w_last = 8'h03;
        8'd2:    w_last = 8'h0F;
        8'd3:    w_last = 8'h3F;
        default: w_last = 8'hFF;
      endcase
    end
  end

  // A cart without RAM (and not MBC2) has nothing to back up.
  assign w_supported = bk_ena & (mbc2 | (cart_ram_size != 8'd0));

  assign w_load_edge = bk_load & ~r_old_load;
  assign w_save_edge = bk_save & ~r_old_save;
  assign w_start     = w_supported & (w_load_edge | w_save_edge);
  assign w_ack_rise  = sd_ack & ~r_old_ack;
  assign w_ack_fall  = ~sd_ack & r_old_ack;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_lba      <= 8'd0;
      r_dir_load <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_old_load <= 1'b0;
      r_old_save <= 1'b0;
      r_old_ack  <= 1'b0;
    end else begin
      // Edge history runs in every state so edges seen while busy are
      // consumed rather than replayed once the transfer ends.
      r_old_load <= bk_load;
      r_old_save <= bk_save;
      r_old_ack  <= sd_ack;
      r_done     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            // Load has priority when both edges land in the same cycle.
            r_lba      <= 8'd0;
            r_dir_load <= w_load_edge;
            r_rd       <= w_load_edge;
            r_wr       <= ~w_load_edge;
            r_busy     <= 1'b1;
            r_state    <= S_REQ;
          end
        end

        S_REQ: begin
          // Only a fresh rising edge counts; an ack still high from the
          // previous sector is ignored.
          if (w_ack_rise) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_state <= S_XFER;
          end
        end

        S_XFER: begin
          if (w_ack_fall) begin
            // Compare before incrementing so sector 0xFF ends the transfer
            // without the 8-bit counter wrapping.
            if (r_lba >= w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_lba   <= r_lba + 8'd1;
              r_rd    <= r_dir_load;
              r_wr    <= ~r_dir_load;
              r_state <= S_REQ;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sd_lba      = {24'd0, r_lba};
  assign sd_rd       = r_rd;
  assign sd_wr       = r_wr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign dbg_state   = r_state;

  // Data path is pure wiring; the SD host absorbs the RAM read latency.
  assign sd_buff_din = bk_q;
  assign bk_data     = sd_buff_dout;
  assign bk_addr     = {r_lba, sd_buff_addr};
  assign bk_wr       = sd_buff_wr & sd_ack & r_dir_load & r_busy;

endmodule

// File: tb/tb_cart_backup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cart_backup_ctrl
//
// Bench for cart_backup_ctrl. The bench plays the SD host: it answers each
// sd_rd/sd_wr request with an sd_ack window, moves a few words inside it and
// checks the cart-RAM side. Expected sector numbers are queued when a
// transfer is started and popped as each request appears.
// -----------------------------------------------------------------------------
module tb_cart_backup_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        bk_ena = 1'b0;
  logic        bk_load = 1'b0;
  logic        bk_save = 1'b0;
  logic        mbc2 = 1'b0;
  logic [7:0]  cart_ram_size = 8'd0;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack = 1'b0;
  logic [7:0]  sd_buff_addr = 8'd0;
  logic        sd_buff_wr = 1'b0;
  logic [15:0] sd_buff_dout = 16'd0;
  logic [15:0] sd_buff_din;
  logic [15:0] bk_addr;
  logic        bk_wr;
  logic [15:0] bk_data;
  logic [15:0] bk_q = 16'd0;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  cart_backup_ctrl dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .bk_ena       (bk_ena),
    .bk_load      (bk_load),
    .bk_save      (bk_save),
    .mbc2         (mbc2),
    .cart_ram_size(cart_ram_size),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_din  (sd_buff_din),
    .bk_addr      (bk_addr),
    .bk_wr        (bk_wr),
    .bk_data      (bk_data),
    .bk_q         (bk_q),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  int done_cnt = 0;
  int req_cnt  = 0;
  int busy_cnt = 0;

  // Outputs change on posedge; sampling on negedge sees settled values.
  always @(negedge clk_sys) begin
    if (done === 1'b1) done_cnt++;
    if (sd_rd === 1'b1 || sd_wr === 1'b1) req_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  // ---------------- driver tasks ----------------
  // Wait for a request, check it against the queue, run one sector window.
  task automatic serve_sector(input bit exp_load, input int n_words,
                              input logic [7:0] first_addr, output bit ok);
    int t;
    logic [31:0] exp_lba;
    logic [1:0]  exp_dir;
    logic [7:0]  a;
    logic [15:0] d;
    ok = 1'b0;
    t = 0;
    exp_dir = exp_load ? 2'b10 : 2'b01;
    while (!(sd_rd === 1'b1 || sd_wr === 1'b1) && t < 40) begin
      @(negedge clk_sys);
      t++;
    end
    n_cmp++;
    if (t >= 40 || exp_q.size() == 0) begin
      n_err++;
      $display("FAIL req_wait: request seen=%0b, queued sectors=%0d, required a request for a queued sector",
               (t < 40), exp_q.size());
      return;
    end
    exp_lba = exp_q.pop_front();
    n_cmp++;
    if (sd_lba !== exp_lba) begin
      n_err++;
      $display("FAIL sd_lba: got %0d, expected %0d", sd_lba, exp_lba);
    end
    n_cmp++;
    if ({sd_rd, sd_wr} !== exp_dir) begin
      n_err++;
      $display("FAIL req_dir: rd/wr got %b, expected %b (lba %0d)", {sd_rd, sd_wr}, exp_dir, exp_lba);
    end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    n_cmp++;
    if ({sd_rd, sd_wr} !== 2'b00) begin
      n_err++;
      $display("FAIL req_drop: rd/wr got %b after ack, expected 00 (lba %0d)", {sd_rd, sd_wr}, exp_lba);
    end
    for (int i = 0; i < n_words; i++) begin
      a = first_addr + 8'(i);
      d = 16'($urandom_range(0, 65535));
      sd_buff_addr = a;
      sd_buff_wr   = 1'b1;
      if (exp_load) sd_buff_dout = d;
      else          bk_q = d;
      #1;
      n_cmp++;
      if (bk_wr !== exp_load) begin
        n_err++;
        $display("FAIL bk_wr: got %b, expected %b (lba %0d addr %h)", bk_wr, exp_load, exp_lba, a);
      end
      if (exp_load) begin
        n_cmp++;
        if (bk_addr !== {exp_lba[7:0], a} || bk_data !== d) begin
          n_err++;
          $display("FAIL bk_word: addr/data got %h/%h, expected %h/%h",
                   bk_addr, bk_data, {exp_lba[7:0], a}, d);
        end
      end else begin
        n_cmp++;
        if (sd_buff_din !== d) begin
          n_err++;
          $display("FAIL sd_buff_din: got %h, expected %h", sd_buff_din, d);
        end
      end
      @(negedge clk_sys);
      sd_buff_wr = 1'b0;
    end
    sd_ack = 1'b0;
    ok = 1'b1;
  endtask

  // Start a transfer, serve every expected sector, then check completion.
  task automatic run_transfer(input bit drive_load, input bit drive_save, input bit exp_load,
                              input int n_sec, input int poke_sector, input logic [7:0] first_addr);
    bit ok;
    int d0;
    int rc;
    exp_q.delete();
    for (int s = 0; s < n_sec; s++) exp_q.push_back(32'(s));
    d0 = done_cnt;
    @(negedge clk_sys);
    if (drive_load) bk_load = 1'b1;
    if (drive_save) bk_save = 1'b1;
    for (int s = 0; s < n_sec; s++) begin
      if (s == poke_sector) bk_save = 1'b1;
      serve_sector(exp_load, 3, first_addr, ok);
      if (!ok) break;
    end
    bk_load = 1'b0;
    bk_save = 1'b0;
    repeat (6) @(negedge clk_sys);
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL done_pulse: done high for %0d cycles, expected 1", done_cnt - d0);
    end
    n_cmp++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL end_state: busy=%b unserved=%0d, expected busy=0 unserved=0", busy, exp_q.size());
    end
    rc = req_cnt;
    repeat (20) @(negedge clk_sys);
    n_cmp++;
    if (req_cnt !== rc) begin
      n_err++;
      $display("FAIL extra_req: %0d request cycles after completion, expected 0", req_cnt - rc);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    repeat (3) @(negedge clk_sys);
    n_cmp++;
    if ({sd_rd, sd_wr, busy, done} !== 4'b0000 || sd_lba !== 32'd0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_hold: rd/wr/busy/done=%b lba=%0d state=%0d, expected 0000/0/0",
               {sd_rd, sd_wr, busy, done}, sd_lba, dbg_state);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    n_cmp++;
    if ({sd_rd, sd_wr, busy, done} !== 4'b0000 || sd_lba !== 32'd0) begin
      n_err++;
      $display("FAIL reset_release: rd/wr/busy/done=%b lba=%0d, expected 0000/0",
               {sd_rd, sd_wr, busy, done}, sd_lba);
    end
  endtask

  task automatic test_save_size2;
    bk_ena = 1'b1; mbc2 = 1'b0; cart_ram_size = 8'd2;
    run_transfer(1'b0, 1'b1, 1'b0, 16, -1, 8'h20);
  endtask

  task automatic test_load_mbc2;
    bk_ena = 1'b1; mbc2 = 1'b1; cart_ram_size = 8'd0;
    run_transfer(1'b1, 1'b0, 1'b1, 2, -1, 8'h3C);
  endtask

  task automatic test_unsupported;
    int rc, bc, dc;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0:       begin bk_ena = 1'b1; mbc2 = 1'b0; cart_ram_size = 8'd0; end
        1:       begin bk_ena = 1'b0; mbc2 = 1'b0; cart_ram_size = 8'd2; end
        default: begin bk_ena = 1'b0; mbc2 = 1'b1; cart_ram_size = 8'd0; end
      endcase
      rc = req_cnt; bc = busy_cnt; dc = done_cnt;
      @(negedge clk_sys);
      bk_save = 1'b1;
      repeat (3) @(negedge clk_sys);
      bk_save = 1'b0;
      repeat (15) @(negedge clk_sys);
      n_cmp++;
      if (req_cnt !== rc || busy_cnt !== bc || done_cnt !== dc) begin
        n_err++;
        $display("FAIL unsupported_%0d: req/busy/done cycles %0d/%0d/%0d, expected 0/0/0",
                 c, req_cnt - rc, busy_cnt - bc, done_cnt - dc);
      end
    end
  endtask

  task automatic test_simultaneous;
    bk_ena = 1'b1; mbc2 = 1'b0; cart_ram_size = 8'd1;
    run_transfer(1'b1, 1'b1, 1'b1, 4, -1, 8'h00);
  endtask

  task automatic test_edge_during_busy;
    bk_ena = 1'b1; mbc2 = 1'b0; cart_ram_size = 8'd1;
    run_transfer(1'b1, 1'b0, 1'b1, 4, 1, 8'hF0);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int t;
    bk_ena = 1'b1; mbc2 = 1'b0; cart_ram_size = 8'h05;
    exp_q.delete();
    for (int s = 0; s < 5; s++) exp_q.push_back(32'(s));
    @(negedge clk_sys);
    bk_save = 1'b1;
    for (int s = 0; s < 5; s++) begin
      serve_sector(1'b0, 2, 8'h00, ok);
      if (!ok) break;
    end
    t = 0;
    while (sd_wr !== 1'b1 && t < 40) begin
      @(negedge clk_sys);
      t++;
    end
    n_cmp++;
    if (sd_lba !== 32'd5 || sd_wr !== 1'b1) begin
      n_err++;
      $display("FAIL mid_sector: wr=%b lba=%0d, expected wr=1 lba=5", sd_wr, sd_lba);
    end
    sd_ack = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (sd_wr !== 1'b0 || busy !== 1'b0 || sd_lba !== 32'd0) begin
      n_err++;
      $display("FAIL reset_abort: wr=%b busy=%b lba=%0d, expected 0/0/0", sd_wr, busy, sd_lba);
    end
    sd_ack  = 1'b0;
    bk_save = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    // Full 256-sector save afterwards: restarts at 0 and ends at 0xFF.
    run_transfer(1'b0, 1'b1, 1'b0, 256, -1, 8'h80);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_save_size2();
    test_load_mbc2();
    test_unsupported();
    test_simultaneous();
    test_edge_during_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
